// File: rtl/wb_openram_pkg.sv
// Shared types, encodings and sizing helpers for the Wishbone-to-OpenRAM arbiter.
package wb_openram_pkg;

  typedef enum logic {
    P_IDLE = 1'b0,
    P_BUSY = 1'b1
  } port_state_e;

  // Which RAM port served the transfer currently in its ack cycle
  localparam logic SRV_RW = 1'b0;
  localparam logic SRV_R  = 1'b1;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned byte_lanes(input int unsigned dw);
    return dw / 8;
  endfunction

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/wb_openram_arbiter_rr.sv
// Combinational round-robin pick: first requester at or after the pointer wins.
module wb_rr_arbiter
  import wb_openram_pkg::*;
#(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = idx_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          gnt_vld_o
);

  always_comb begin
    int unsigned j;
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    j         = 0;
    for (int unsigned off = 0; off < N; off++) begin
      j = (32'(ptr_i) + off) % N;
      if (!gnt_vld_o && req_i[j]) begin
        gnt_vld_o = 1'b1;
        gnt_o[j]  = 1'b1;
        gnt_idx_o = IW'(j);
      end
    end
  end

endmodule

// File: rtl/wb_openram_arbiter.sv
// N Wishbone slave ports sharing one OpenRAM 1RW+1R macro; reads prefer the R
// port, everything else (and leftover reads) goes round-robin to the RW port.
module wb_openram_arbiter
  import wb_openram_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                                  wb_clk_i,
  input  logic                                  wb_rst_i,
  input  logic [NUM_PORTS-1:0]                  wbs_stb_i,
  input  logic [NUM_PORTS-1:0]                  wbs_cyc_i,
  input  logic [NUM_PORTS-1:0]                  wbs_we_i,
  input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0]   wbs_sel_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]       wbs_dat_i,
  input  logic [NUM_PORTS*(ADDR_WIDTH+2)-1:0]   wbs_adr_i,
  output logic [NUM_PORTS-1:0]                  wbs_ack_o,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]       wbs_dat_o,
  output logic                                  ram_clk0,
  output logic                                  ram_csb0,
  output logic                                  ram_web0,
  output logic [(DATA_WIDTH/8)-1:0]             ram_wmask0,
  output logic [ADDR_WIDTH-1:0]                 ram_addr0,
  output logic [DATA_WIDTH-1:0]                 ram_din0,
  input  logic [DATA_WIDTH-1:0]                 ram_dout0,
  output logic                                  ram_clk1,
  output logic                                  ram_csb1,
  output logic [ADDR_WIDTH-1:0]                 ram_addr1,
  input  logic [DATA_WIDTH-1:0]                 ram_dout1
);

  localparam int unsigned NB  = byte_lanes(DATA_WIDTH);
  localparam int unsigned IW  = idx_width(NUM_PORTS);
  localparam int unsigned AW2 = ADDR_WIDTH + 2;

  logic [ADDR_WIDTH-1:0] adr_w [NUM_PORTS];
  logic [DATA_WIDTH-1:0] dat_w [NUM_PORTS];
  logic [NB-1:0]         sel_w [NUM_PORTS];

  logic [NUM_PORTS-1:0] elig;
  logic [NUM_PORTS-1:0] r_req;
  logic [NUM_PORTS-1:0] rw_req;
  logic [NUM_PORTS-1:0] r_gnt;
  logic [NUM_PORTS-1:0] rw_gnt;
  logic [IW-1:0]        r_idx;
  logic [IW-1:0]        rw_idx;
  logic                 r_vld;
  logic                 rw_vld;
  logic [IW-1:0]        r_ptr_q;
  logic [IW-1:0]        r_ptr_d;
  logic [IW-1:0]        rw_ptr_q;
  logic [IW-1:0]        rw_ptr_d;

  assign ram_clk0 = wb_clk_i;
  assign ram_clk1 = wb_clk_i;

  // R port takes reads first; RW port serves whoever is left, reads or writes
  assign r_req  = elig & ~wbs_we_i;
  assign rw_req = elig & ~r_gnt;

  wb_rr_arbiter #(.N(NUM_PORTS), .IW(IW)) u_r_arb (
    .req_i     (r_req),
    .ptr_i     (r_ptr_q),
    .gnt_o     (r_gnt),
    .gnt_idx_o (r_idx),
    .gnt_vld_o (r_vld)
  );

  wb_rr_arbiter #(.N(NUM_PORTS), .IW(IW)) u_rw_arb (
    .req_i     (rw_req),
    .ptr_i     (rw_ptr_q),
    .gnt_o     (rw_gnt),
    .gnt_idx_o (rw_idx),
    .gnt_vld_o (rw_vld)
  );

  always_comb begin
    r_ptr_d  = r_ptr_q;
    rw_ptr_d = rw_ptr_q;
    if (r_vld)  r_ptr_d  = IW'(rr_next(32'(r_idx), NUM_PORTS));
    if (rw_vld) rw_ptr_d = IW'(rr_next(32'(rw_idx), NUM_PORTS));
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ptr_q  <= '0;
      rw_ptr_q <= '0;
    end else begin
      r_ptr_q  <= r_ptr_d;
      rw_ptr_q <= rw_ptr_d;
    end
  end

  // RAM control is combinational so the macro captures it at the end of the grant cycle
  always_comb begin
    ram_csb0   = 1'b1;
    ram_web0   = 1'b1;
    ram_wmask0 = '0;
    ram_addr0  = '0;
    ram_din0   = '0;
    if (rw_vld) begin
      ram_csb0   = 1'b0;
      ram_web0   = ~wbs_we_i[rw_idx];
      ram_addr0  = adr_w[rw_idx];
      ram_din0   = dat_w[rw_idx];
      ram_wmask0 = wbs_we_i[rw_idx] ? sel_w[rw_idx] : '0;
    end
  end

  assign ram_csb1  = ~r_vld;
  assign ram_addr1 = r_vld ? adr_w[r_idx] : '0;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    port_state_e state_q;
    port_state_e state_d;
    logic        srv_q;
    logic        srv_d;
    logic        rd_q;
    logic        rd_d;
    logic [1:0]  adr_lo_unused;

    assign adr_w[i]      = wbs_adr_i[i*AW2+2 +: ADDR_WIDTH];
    assign adr_lo_unused = wbs_adr_i[i*AW2 +: 2];
    assign dat_w[i]      = wbs_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
    assign sel_w[i]      = wbs_sel_i[i*NB +: NB];

    assign elig[i] = wbs_cyc_i[i] & wbs_stb_i[i] & (state_q == P_IDLE) & ~wb_rst_i;

    always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
        state_q <= P_IDLE;
        srv_q   <= SRV_RW;
        rd_q    <= 1'b0;
      end else begin
        state_q <= state_d;
        srv_q   <= srv_d;
        rd_q    <= rd_d;
      end
    end

    // One-cycle BUSY: the ack cycle always falls back to IDLE, even on abort
    always_comb begin
      state_d = state_q;
      srv_d   = srv_q;
      rd_d    = rd_q;
      case (state_q)
        P_IDLE: begin
          if (r_gnt[i] || rw_gnt[i]) begin
            state_d = P_BUSY;
            srv_d   = r_gnt[i] ? SRV_R : SRV_RW;
            rd_d    = ~wbs_we_i[i];
          end
        end
        P_BUSY:  state_d = P_IDLE;
        default: state_d = P_IDLE;
      endcase
    end

    assign wbs_ack_o[i] = (state_q == P_BUSY) & wbs_cyc_i[i] & ~wb_rst_i;
    assign wbs_dat_o[i*DATA_WIDTH +: DATA_WIDTH] =
      ((state_q == P_BUSY) && rd_q) ? ((srv_q == SRV_R) ? ram_dout1 : ram_dout0) : '0;
  end

endmodule

// File: tb/tb_wb_openram_arbiter.sv
// Directed bench for wb_openram_arbiter with four ports and a behavioural 1RW+1R RAM.
module tb_wb_openram_arbiter;

  localparam int unsigned NP = 4;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned NB = DW / 8;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [NP-1:0]      stb, cyc, we;
  logic [NP*NB-1:0]   sel;
  logic [NP*DW-1:0]   dat;
  logic [NP*(AW+2)-1:0] adr;
  logic [NP-1:0]      ack;
  logic [NP*DW-1:0]   dato;
  logic               ram_clk0, ram_csb0, ram_web0, ram_clk1, ram_csb1;
  logic [NB-1:0]      ram_wmask0;
  logic [AW-1:0]      ram_addr0, ram_addr1;
  logic [DW-1:0]      ram_din0, ram_dout0, ram_dout1;
  logic [DW-1:0]      mem [256];

  int n_cmp = 0;
  int n_bad = 0;

  wb_openram_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .wb_clk_i  (clk),        .wb_rst_i  (rst),
    .wbs_stb_i (stb),        .wbs_cyc_i (cyc),
    .wbs_we_i  (we),         .wbs_sel_i (sel),
    .wbs_dat_i (dat),        .wbs_adr_i (adr),
    .wbs_ack_o (ack),        .wbs_dat_o (dato),
    .ram_clk0  (ram_clk0),   .ram_csb0  (ram_csb0),
    .ram_web0  (ram_web0),   .ram_wmask0(ram_wmask0),
    .ram_addr0 (ram_addr0),  .ram_din0  (ram_din0),
    .ram_dout0 (ram_dout0),  .ram_clk1  (ram_clk1),
    .ram_csb1  (ram_csb1),   .ram_addr1 (ram_addr1),
    .ram_dout1 (ram_dout1)
  );

  always #5 clk = ~clk;

  // RAM model: RW port with byte mask, preloaded while reset is held
  always @(posedge ram_clk0) begin
    if (rst) begin
      mem[1] <= 32'hDEADBEEF;
      mem[2] <= 32'hAAAAAAAA;
      mem[5] <= 32'h55555555;
      mem[6] <= 32'h66666666;
    end else if (!ram_csb0) begin
      if (!ram_web0) begin
        for (int b = 0; b < int'(NB); b++)
          if (ram_wmask0[b]) mem[ram_addr0][b*8 +: 8] <= ram_din0[b*8 +: 8];
      end else begin
        ram_dout0 <= mem[ram_addr0];
      end
    end
  end

  always @(posedge ram_clk1) begin
    if (!ram_csb1) ram_dout1 <= mem[ram_addr1];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    cyc = '0; stb = '0; we = '0; sel = '0; dat = '0; adr = '0;
  endtask

  task automatic set_port(input int p, input logic c, input logic s, input logic w,
                          input logic [NB-1:0] sl, input logic [DW-1:0] d,
                          input logic [AW+1:0] a);
    cyc[p] = c; stb[p] = s; we[p] = w;
    sel[p*NB +: NB] = sl;
    dat[p*DW +: DW] = d;
    adr[p*(AW+2) +: (AW+2)] = a;
  endtask

  task automatic do_reset();
    tick();
    idle_all();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    idle_all();
    rst = 1'b1;
    set_port(0, 1'b1, 1'b1, 1'b0, '0, '0, 10'h004);
    set_port(1, 1'b1, 1'b1, 1'b1, 4'hF, 32'h12345678, 10'h00C);
    tick(); #1;
    n_cmp++; if (ack !== 4'b0000) begin n_bad++; $display("FAIL reset_ack: got %b want 0000", ack); end
    n_cmp++; if (ram_csb0 !== 1'b1) begin n_bad++; $display("FAIL reset_csb0: got %b want 1", ram_csb0); end
    n_cmp++; if (ram_csb1 !== 1'b1) begin n_bad++; $display("FAIL reset_csb1: got %b want 1", ram_csb1); end
    n_cmp++; if (ram_web0 !== 1'b1) begin n_bad++; $display("FAIL reset_web0: got %b want 1", ram_web0); end
    n_cmp++; if (ram_wmask0 !== 4'h0) begin n_bad++; $display("FAIL reset_wmask0: got %h want 0", ram_wmask0); end
    n_cmp++; if (ram_addr0 !== 8'h00 || ram_addr1 !== 8'h00) begin n_bad++; $display("FAIL reset_addr: got %h/%h want 00/00", ram_addr0, ram_addr1); end
    n_cmp++; if (ram_din0 !== 32'h0) begin n_bad++; $display("FAIL reset_din0: got %h want 0", ram_din0); end
    n_cmp++; if (dato !== '0) begin n_bad++; $display("FAIL reset_dato: got %h want 0", dato); end
    idle_all();
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    do_reset();
    set_port(0, 1'b1, 1'b1, 1'b0, '0, '0, 10'h004);
    #1;
    n_cmp++; if (ram_csb1 !== 1'b0) begin n_bad++; $display("FAIL rd_csb1: got %b want 0", ram_csb1); end
    n_cmp++; if (ram_addr1 !== 8'd1) begin n_bad++; $display("FAIL rd_addr1: got %h want 01", ram_addr1); end
    n_cmp++; if (ram_csb0 !== 1'b1) begin n_bad++; $display("FAIL rd_csb0: got %b want 1", ram_csb0); end
    tick(); #1;
    n_cmp++; if (ack !== 4'b0001) begin n_bad++; $display("FAIL rd_ack: got %b want 0001", ack); end
    n_cmp++; if (dato[31:0] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_data: got %h want deadbeef", dato[31:0]); end
    n_cmp++; if (ram_csb1 !== 1'b1) begin n_bad++; $display("FAIL rd_busy_csb1: got %b want 1", ram_csb1); end
    tick();
    idle_all();
    #1;
    n_cmp++; if (ack !== 4'b0000) begin n_bad++; $display("FAIL rd_ack_t2: got %b want 0000", ack); end
  endtask

  task automatic test_byte_write();
    do_reset();
    set_port(1, 1'b1, 1'b1, 1'b1, 4'b0010, 32'h11223344, 10'h008);
    #1;
    n_cmp++; if (ram_csb0 !== 1'b0 || ram_web0 !== 1'b0) begin n_bad++; $display("FAIL wr_ctl: got csb0=%b web0=%b want 0/0", ram_csb0, ram_web0); end
    n_cmp++; if (ram_wmask0 !== 4'b0010) begin n_bad++; $display("FAIL wr_wmask: got %b want 0010", ram_wmask0); end
    n_cmp++; if (ram_addr0 !== 8'd2) begin n_bad++; $display("FAIL wr_addr0: got %h want 02", ram_addr0); end
    n_cmp++; if (ram_din0 !== 32'h11223344) begin n_bad++; $display("FAIL wr_din0: got %h want 11223344", ram_din0); end
    n_cmp++; if (ram_csb1 !== 1'b1) begin n_bad++; $display("FAIL wr_csb1: got %b want 1", ram_csb1); end
    tick(); #1;
    n_cmp++; if (ack !== 4'b0010) begin n_bad++; $display("FAIL wr_ack: got %b want 0010", ack); end
    n_cmp++; if (dato[63:32] !== 32'h0) begin n_bad++; $display("FAIL wr_ack_data: got %h want 0", dato[63:32]); end
    tick();
    idle_all();
    set_port(2, 1'b1, 1'b1, 1'b0, '0, '0, 10'h008);
    #1;
    n_cmp++; if (ram_csb1 !== 1'b0 || ram_addr1 !== 8'd2) begin n_bad++; $display("FAIL wr_readback_req: got csb1=%b addr1=%h want 0/02", ram_csb1, ram_addr1); end
    tick(); #1;
    n_cmp++; if (ack !== 4'b0100) begin n_bad++; $display("FAIL wr_readback_ack: got %b want 0100", ack); end
    n_cmp++; if (dato[95:64] !== 32'hAAAA33AA) begin n_bad++; $display("FAIL wr_readback_data: got %h want aaaa33aa", dato[95:64]); end
    tick();
    idle_all();
  endtask

  task automatic test_dual_issue();
    do_reset();
    set_port(0, 1'b1, 1'b1, 1'b0, '0, '0, 10'h014);
    set_port(1, 1'b1, 1'b1, 1'b0, '0, '0, 10'h018);
    #1;
    n_cmp++; if (ram_csb1 !== 1'b0 || ram_addr1 !== 8'd5) begin n_bad++; $display("FAIL dual_r: got csb1=%b addr1=%h want 0/05", ram_csb1, ram_addr1); end
    n_cmp++; if (ram_csb0 !== 1'b0 || ram_web0 !== 1'b1 || ram_addr0 !== 8'd6) begin n_bad++; $display("FAIL dual_rw: got csb0=%b web0=%b addr0=%h want 0/1/06", ram_csb0, ram_web0, ram_addr0); end
    n_cmp++; if (ram_wmask0 !== 4'h0) begin n_bad++; $display("FAIL dual_wmask: got %h want 0", ram_wmask0); end
    tick(); #1;
    n_cmp++; if (ack !== 4'b0011) begin n_bad++; $display("FAIL dual_ack: got %b want 0011", ack); end
    n_cmp++; if (dato[31:0] !== 32'h55555555) begin n_bad++; $display("FAIL dual_data0: got %h want 55555555", dato[31:0]); end
    n_cmp++; if (dato[63:32] !== 32'h66666666) begin n_bad++; $display("FAIL dual_data1: got %h want 66666666", dato[63:32]); end
    tick();
    idle_all();
  endtask

  task automatic test_fairness();
    do_reset();
    for (int p = 0; p < int'(NP); p++)
      set_port(p, 1'b1, 1'b1, 1'b1, 4'hF, 32'hC0DE0000 + 32'(p), 10'((8 + p) * 4));
    for (int c = 0; c < 8; c++) begin
      #1;
      n_cmp++; if (ram_csb0 !== 1'b0 || ram_addr0 !== 8'(8 + c % 4)) begin n_bad++; $display("FAIL fair_grant c=%0d: got csb0=%b addr0=%h want 0/%h", c, ram_csb0, ram_addr0, 8'(8 + c % 4)); end
      n_cmp++; if (ram_din0 !== 32'hC0DE0000 + 32'(c % 4)) begin n_bad++; $display("FAIL fair_din c=%0d: got %h want %h", c, ram_din0, 32'hC0DE0000 + 32'(c % 4)); end
      if (c > 0) begin
        n_cmp++; if (ack !== 4'(1 << ((c - 1) % 4))) begin n_bad++; $display("FAIL fair_ack c=%0d: got %b want %b", c, ack, 4'(1 << ((c - 1) % 4))); end
      end
      tick();
    end
    idle_all();
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_port(1, 1'b1, 1'b1, 1'b1, 4'hF, 32'h0BADF00D, 10'h030);
    #1;
    n_cmp++; if (ram_csb0 !== 1'b0 || ram_addr0 !== 8'd12) begin n_bad++; $display("FAIL rstmid_pre: got csb0=%b addr0=%h want 0/0c", ram_csb0, ram_addr0); end
    tick();
    rst = 1'b1;
    set_port(3, 1'b1, 1'b1, 1'b1, 4'hF, 32'h33333333, 10'h034);
    #1;
    n_cmp++; if (ack !== 4'b0000) begin n_bad++; $display("FAIL rstmid_ack: got %b want 0000", ack); end
    n_cmp++; if (ram_csb0 !== 1'b1 || ram_csb1 !== 1'b1) begin n_bad++; $display("FAIL rstmid_csb: got %b/%b want 1/1", ram_csb0, ram_csb1); end
    tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (ack !== 4'b0000) begin n_bad++; $display("FAIL rstmid_noack: got %b want 0000", ack); end
    n_cmp++; if (ram_csb0 !== 1'b0 || ram_addr0 !== 8'd12) begin n_bad++; $display("FAIL rstmid_ptr0: got csb0=%b addr0=%h want 0/0c", ram_csb0, ram_addr0); end
    tick(); #1;
    n_cmp++; if (ack !== 4'b0010) begin n_bad++; $display("FAIL rstmid_ack_after: got %b want 0010", ack); end
    n_cmp++; if (ram_csb0 !== 1'b0 || ram_addr0 !== 8'd13) begin n_bad++; $display("FAIL rstmid_next: got csb0=%b addr0=%h want 0/0d", ram_csb0, ram_addr0); end
    tick();
    idle_all();
    tick();
  endtask

  task automatic test_abort();
    do_reset();
    set_port(0, 1'b1, 1'b1, 1'b0, '0, '0, 10'h004);
    #1;
    n_cmp++; if (ram_csb1 !== 1'b0) begin n_bad++; $display("FAIL abort_grant: got csb1=%b want 0", ram_csb1); end
    tick();
    set_port(0, 1'b0, 1'b0, 1'b0, '0, '0, 10'h004);
    #1;
    n_cmp++; if (ack !== 4'b0000) begin n_bad++; $display("FAIL abort_ack: got %b want 0000", ack); end
    tick();
    set_port(0, 1'b1, 1'b1, 1'b0, '0, '0, 10'h004);
    #1;
    n_cmp++; if (ram_csb1 !== 1'b0 || ram_addr1 !== 8'd1) begin n_bad++; $display("FAIL abort_regrant: got csb1=%b addr1=%h want 0/01", ram_csb1, ram_addr1); end
    tick(); #1;
    n_cmp++; if (ack !== 4'b0001 || dato[31:0] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL abort_reack: got ack=%b data=%h want 0001/deadbeef", ack, dato[31:0]); end
    tick();
    idle_all();
  endtask

  initial begin
    idle_all();
    test_reset();
    test_single_read();
    test_byte_write();
    test_dual_issue();
    test_fairness();
    test_reset_mid();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
